// File: rtl/wb_stage_if.sv
// MEM->WB stage bus: instruction fields from MEM, register-file write port and
// retire counter back out. The slave modport is the WB stage itself.
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  // mem_valid/wb_ready: an instruction moves into WB on a rising edge where
  // mem_valid=1 and wb_ready=1; flush on that edge kills it instead.
  logic              mem_valid;
  logic              wb_ready;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] mem_alu_res;
  logic [DATA_W-1:0] mem_mem_data;
  logic [DATA_W-1:0] mem_pc_link;
  logic [DATA_W-1:0] mem_csr_data;
  logic [1:0]        mem_wb_sel;
  logic [1:0]        mem_ld_size;
  logic              mem_ld_uns;
  logic [OFF_W-1:0]  mem_addr_lo;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_wb_en;
  logic              wb_reg_en;
  logic [REG_AW-1:0] wb_reg_addr;
  logic [DATA_W-1:0] wb_reg_data;
  logic [CNT_W-1:0]  wb_retire_cnt;

  modport master (
    output mem_valid, stall, flush, mem_alu_res, mem_mem_data, mem_pc_link,
           mem_csr_data, mem_wb_sel, mem_ld_size, mem_ld_uns, mem_addr_lo,
           mem_rd, mem_wb_en,
    input  wb_ready, wb_reg_en, wb_reg_addr, wb_reg_data, wb_retire_cnt
  );

  modport slave (
    input  mem_valid, stall, flush, mem_alu_res, mem_mem_data, mem_pc_link,
           mem_csr_data, mem_wb_sel, mem_ld_size, mem_ld_uns, mem_addr_lo,
           mem_rd, mem_wb_en,
    output wb_ready, wb_reg_en, wb_reg_addr, wb_reg_data, wb_retire_cnt
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: formats loads, selects the result source and registers
// the register-file write port; counts retired instructions.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);
  logic              valid_q, valid_d;
  logic              en_q, en_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] ld_fmt;
  logic [DATA_W-1:0] sel_data;

  // Load formatting: the casts zero- or sign-extend the selected lane.
  always_comb begin
    lane = bus.mem_mem_data >> {bus.mem_addr_lo, 3'b000};
    case (bus.mem_ld_size)
      2'b00:   ld_fmt = bus.mem_ld_uns ? DATA_W'(lane[7:0])
                                       : DATA_W'($signed(lane[7:0]));
      2'b01:   ld_fmt = bus.mem_ld_uns ? DATA_W'(lane[15:0])
                                       : DATA_W'($signed(lane[15:0]));
      2'b10:   ld_fmt = bus.mem_ld_uns ? DATA_W'(lane[31:0])
                                       : DATA_W'($signed(lane[31:0]));
      default: ld_fmt = (DATA_W == 64) ? lane
                      : (bus.mem_ld_uns ? DATA_W'(lane[31:0])
                                        : DATA_W'($signed(lane[31:0])));
    endcase

    case (bus.mem_wb_sel)
      2'b00:   sel_data = bus.mem_alu_res;
      2'b01:   sel_data = ld_fmt;
      2'b10:   sel_data = bus.mem_pc_link;
      default: sel_data = bus.mem_csr_data;
    endcase
  end

  // Stall freezes everything, flush included; otherwise the counter retires
  // whatever is currently valid and the register takes the next instruction.
  always_comb begin
    valid_d = valid_q;
    en_d    = en_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (!bus.stall) begin
      valid_d = bus.mem_valid & ~bus.flush;
      cnt_d   = cnt_q + CNT_W'(valid_q);
      if (valid_d) begin
        en_d   = bus.mem_wb_en & (bus.mem_rd != '0);
        addr_d = bus.mem_rd;
        data_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wb_ready      = ~bus.stall;
  assign bus.wb_reg_en     = valid_q & en_q;
  assign bus.wb_reg_addr   = addr_q;
  assign bus.wb_reg_data   = data_q;
  assign bus.wb_retire_cnt = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed plus random bench for wb_stage with an expected-result queue.
module tb_wb_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 32;
  localparam int EW = 1 + AW + DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();

  wb_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp;
  logic          m_valid;
  logic [CW-1:0] exp_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference load/source selection written with byte slicing of a padded word.
  function automatic logic [31:0] model_data(
    input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
    input logic [31:0] link, input logic [31:0] csr, input logic [1:0] size,
    input logic uns, input logic [1:0] alo);
    logic [63:0] md;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    md = {32'b0, mem};
    b  = md[8*alo +: 8];
    h  = md[8*alo +: 16];
    case (size)
      2'd0:    r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = md[8*alo +: 32];
    endcase
    case (sel)
      2'd0:    return alu;
      2'd1:    return r;
      2'd2:    return link;
      default: return csr;
    endcase
  endfunction

  task automatic set_in(input logic v, input logic st, input logic fl,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] link,
                        input logic [31:0] csr, input logic [1:0] size,
                        input logic uns, input logic [1:0] alo,
                        input logic [AW-1:0] rd, input logic wen);
    bus.mem_valid    = v;
    bus.stall        = st;
    bus.flush        = fl;
    bus.mem_wb_sel   = sel;
    bus.mem_alu_res  = alu;
    bus.mem_mem_data = mem;
    bus.mem_pc_link  = link;
    bus.mem_csr_data = csr;
    bus.mem_ld_size  = size;
    bus.mem_ld_uns   = uns;
    bus.mem_addr_lo  = alo;
    bus.mem_rd       = rd;
    bus.mem_wb_en    = wen;
  endtask

  // Push the expectation for the coming edge, clock once, pop and compare.
  task automatic step(input string tag);
    logic [EW-1:0] e;
    #1;
    chk({tag, ".ready"}, {63'b0, bus.wb_ready}, {63'b0, ~bus.stall});
    if (!bus.stall) begin
      if (m_valid) exp_cnt++;
      m_valid = bus.mem_valid & ~bus.flush;
      if (m_valid)
        last_exp = {bus.mem_wb_en & (bus.mem_rd != 0), bus.mem_rd,
                    model_data(bus.mem_wb_sel, bus.mem_alu_res, bus.mem_mem_data,
                               bus.mem_pc_link, bus.mem_csr_data, bus.mem_ld_size,
                               bus.mem_ld_uns, bus.mem_addr_lo)};
      else
        last_exp[EW-1] = 1'b0;
    end
    exp_q.push_back(last_exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".en"}, {63'b0, bus.wb_reg_en}, {63'b0, e[EW-1]});
      if (e[EW-1]) begin
        chk({tag, ".addr"}, 64'(bus.wb_reg_addr), 64'(e[EW-2 -: AW]));
        chk({tag, ".data"}, 64'(bus.wb_reg_data), 64'(e[DW-1:0]));
      end
    end
    chk({tag, ".cnt"}, 64'(bus.wb_retire_cnt), 64'(exp_cnt));
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    exp_cnt  = '0;
    last_exp = '0;
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, '0, 0);
    #12;
    chk("rst.en",   {63'b0, bus.wb_reg_en}, 64'd0);
    chk("rst.addr", 64'(bus.wb_reg_addr), 64'd0);
    chk("rst.data", 64'(bus.wb_reg_data), 64'd0);
    chk("rst.cnt",  64'(bus.wb_retire_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ALU path
    set_in(1, 0, 0, 2'd0, 32'h1234_5678, 0, 0, 0, 2'd2, 0, 2'd0, 5'd5, 1);
    step("alu");
    chk("alu.lit_data", 64'(bus.wb_reg_data), 64'h1234_5678);
    chk("alu.lit_cnt",  64'(bus.wb_retire_cnt), 64'd0);

    // signed / unsigned byte load
    set_in(1, 0, 0, 2'd1, 0, 32'h80FF_7F00, 0, 0, 2'd0, 0, 2'd3, 5'd6, 1);
    step("lb");
    chk("lb.lit_data", 64'(bus.wb_reg_data), 64'hFFFF_FF80);
    chk("alu.lit_cnt1", 64'(bus.wb_retire_cnt), 64'd1);
    set_in(1, 0, 0, 2'd1, 0, 32'h80FF_7F00, 0, 0, 2'd0, 1, 2'd3, 5'd6, 1);
    step("lbu");
    chk("lbu.lit_data", 64'(bus.wb_reg_data), 64'h0000_0080);

    // half load, dword size treated as word, CSR source
    set_in(1, 0, 0, 2'd1, 0, 32'h8001_0000, 0, 0, 2'd1, 0, 2'd2, 5'd9, 1);
    step("lh");
    chk("lh.lit_data", 64'(bus.wb_reg_data), 64'hFFFF_8001);
    set_in(1, 0, 0, 2'd1, 0, 32'h8000_0001, 0, 0, 2'd3, 0, 2'd0, 5'd10, 1);
    step("ld_as_w");
    chk("ld_as_w.lit_data", 64'(bus.wb_reg_data), 64'h8000_0001);
    set_in(1, 0, 0, 2'd3, 0, 0, 0, 32'hC5C0_0300, 2'd2, 0, 2'd0, 5'd31, 1);
    step("csr");

    // rd=0 suppression still retires
    set_in(1, 0, 0, 2'd2, 0, 0, 32'h104, 0, 2'd2, 0, 2'd0, 5'd0, 1);
    step("rd0");
    chk("rd0.lit_en", {63'b0, bus.wb_reg_en}, 64'd0);
    set_in(0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd2, 0, 2'd0, 5'd0, 0);
    step("rd0_retire");

    // stall with flush holds everything, then flush kills the next capture
    set_in(1, 0, 0, 2'd0, 32'hA5A5_0F0F, 0, 0, 0, 2'd2, 0, 2'd0, 5'd7, 1);
    step("pre_stall");
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 2'd0, 32'h0BAD_0BAD, 0, 0, 0, 2'd2, 0, 2'd0, 5'd3, 1);
      step("stall");
      chk("stall.lit_data", 64'(bus.wb_reg_data), 64'hA5A5_0F0F);
      chk("stall.lit_en", {63'b0, bus.wb_reg_en}, 64'd1);
    end
    set_in(1, 0, 1, 2'd0, 32'h0BAD_0BAD, 0, 0, 0, 2'd2, 0, 2'd0, 5'd3, 1);
    step("flush");
    chk("flush.lit_en", {63'b0, bus.wb_reg_en}, 64'd0);

    // async reset mid-operation with cnt=7 and a live write
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 8; i++) begin
      set_in(1, 0, 0, 2'd0, 32'(i * 17), 0, 0, 0, 2'd2, 0, 2'd0, AW'(i), 1);
      step("fill");
    end
    chk("pre_rst.cnt", 64'(bus.wb_retire_cnt), 64'd7);
    set_in(0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd2, 0, 2'd0, '0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst.en",   {63'b0, bus.wb_reg_en}, 64'd0);
    chk("arst.addr", 64'(bus.wb_reg_addr), 64'd0);
    chk("arst.data", 64'(bus.wb_reg_data), 64'd0);
    chk("arst.cnt",  64'(bus.wb_retire_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    set_in(1, 0, 0, 2'd0, 32'hFEED_0001, 0, 0, 0, 2'd2, 0, 2'd0, 5'd12, 1);
    step("post_rst");
    set_in(0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd2, 0, 2'd0, '0, 0);
    step("post_rst_idle");

    // random mix of sources, load shapes, stalls and flushes
    for (int i = 0; i < 40; i++) begin
      set_in($urandom_range(3, 0) != 0, $urandom_range(3, 0) == 0,
             $urandom_range(4, 0) == 0, 2'($urandom_range(3, 0)), $urandom,
             $urandom, $urandom, $urandom, 2'($urandom_range(3, 0)),
             1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
             AW'($urandom_range(31, 0)), 1'($urandom_range(1, 0)));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
